// File: rtl/cpu_sequencer_pkg.sv
// Shared types and defaults for the CPU control sequencer.
// Holds the FSM state encodings, parameter defaults and the branch-decision helper.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_RESET     = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_EXECUTE   = 3'd3,
        SEQ_WRITEBACK = 3'd4,
        SEQ_HALT      = 3'd5
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT      = 32'd0;
    localparam int unsigned FETCH_TIMEOUT_DEFAULT = 16;

    // A jump is taken when it is unconditional, or conditional with differing operands.
    function automatic logic branch_taken(input logic do_jump,
                                          input logic alu_jump,
                                          input logic alu_ne);
        return do_jump & (~alu_jump | alu_ne);
    endfunction

endpackage

// File: rtl/cpu_sequencer_next_pc.sv
// Combinational next-PC selection: jump target as-is when taken, else pc+1 (mod 2^32).
module cpu_next_pc
    import cpu_sequencer_pkg::*;
(
    input  logic        do_jump,
    input  logic        alu_jump,
    input  logic        alu_ne,
    input  logic [31:0] jump_address,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] next_pc
);

    assign taken   = branch_taken(do_jump, alu_jump, alu_ne);
    assign next_pc = taken ? jump_address : pc + 32'd1;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK, with HALT.
// Optional fetch watchdog and retire counter are enabled by defining CPU_SEQ_WATCHDOG_EN.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    input  logic        do_jump,
    input  logic        alu_jump,
    input  logic [31:0] jump_address,
    input  logic        write_enable,
    input  logic        alu_ne,
    input  logic        halt_req,
    output logic        rf_we,
    output logic [31:0] pc,
`ifdef CPU_SEQ_WATCHDOG_EN
    output logic [31:0] retired,
`endif
    output logic        halted,
    output logic        fault
);

    seq_state_e  state;
    seq_state_e  state_next;
    logic        fetch_done;
    logic        wd_expired;
    logic        taken_c;
    logic [31:0] next_pc_c;
    logic [31:0] next_pc_q;

    // imem_req is only high in FETCH, so this is the one place an ack is honoured.
    assign fetch_done = (state == SEQ_FETCH) && imem_req && imem_ack;
    assign imem_addr  = pc;

    cpu_next_pc u_next_pc (
        .do_jump      (do_jump),
        .alu_jump     (alu_jump),
        .alu_ne       (alu_ne),
        .jump_address (jump_address),
        .pc           (pc),
        .taken        (taken_c),
        .next_pc      (next_pc_c)
    );

    // The branch decision is captured through next_pc_q; taken is kept on the
    // sub-module boundary for visibility only.
    logic unused_taken;
    assign unused_taken = taken_c;

    // State register; reset overrides every other event in the cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= SEQ_RESET;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            SEQ_RESET:     state_next = SEQ_FETCH;
            SEQ_FETCH: begin
                if (fetch_done)      state_next = SEQ_DECODE;
                else if (wd_expired) state_next = SEQ_HALT;
            end
            SEQ_DECODE:    state_next = SEQ_EXECUTE;
            SEQ_EXECUTE:   state_next = SEQ_WRITEBACK;
            SEQ_WRITEBACK: state_next = halt_req ? SEQ_HALT : SEQ_FETCH;
            SEQ_HALT:      state_next = SEQ_HALT;
            default:       state_next = SEQ_RESET;
        endcase
    end

    // Combinational outputs decoded from the current state.
    always_comb begin
        rf_we  = (state == SEQ_WRITEBACK) && write_enable && !do_jump;
        halted = (state == SEQ_HALT);
    end

    // Datapath: registered fetch request, IR, latched branch result and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_req    <= 1'b0;
            // NOTE: IR is a real reset flop (not an uninitialised store) so the decoder sees 0 out of reset.
            instruction <= '0;
            next_pc_q   <= RESET_PC;
            pc          <= RESET_PC;
        end else begin
            imem_req <= (state_next == SEQ_FETCH);
            if (fetch_done)
                instruction <= imem_rdata;
            if (state == SEQ_EXECUTE)
                next_pc_q <= next_pc_c;
            if (state == SEQ_WRITEBACK)
                pc <= next_pc_q;
        end
    end

`ifdef CPU_SEQ_WATCHDOG_EN
    logic [31:0] wd_count;
    logic        fault_q;

    // The limit cycle only faults if no ack arrives in it; a same-cycle ack wins.
    assign wd_expired = (state == SEQ_FETCH) && !fetch_done &&
                        (wd_count == 32'(FETCH_TIMEOUT - 1));
    assign fault      = fault_q;

    // Fetch watchdog, sticky fault flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count <= '0;
            fault_q  <= 1'b0;
            retired  <= '0;
        end else begin
            if (state != SEQ_FETCH) wd_count <= '0;
            else if (!fetch_done)   wd_count <= wd_count + 32'd1;
            if (wd_expired)
                fault_q <= 1'b1;
            if (state == SEQ_WRITEBACK)
                retired <= retired + 32'd1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign fault      = 1'b0;

    // The timeout only matters when the watchdog is built in.
    logic unused_fetch_timeout;
    assign unused_fetch_timeout = (FETCH_TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
// Inputs change and outputs are checked on the falling clock edge.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic        do_jump = 1'b0;
    logic        alu_jump = 1'b0;
    logic [31:0] jump_address = '0;
    logic        write_enable = 1'b0;
    logic        alu_ne = 1'b0;
    logic        halt_req = 1'b0;
    logic        rf_we;
    logic [31:0] pc;
    logic        halted;
    logic        fault;
`ifdef CPU_SEQ_WATCHDOG_EN
    logic [31:0] retired;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = '0;
    logic [31:0] model_ir = '0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(32'd0), .FETCH_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .do_jump      (do_jump),
        .alu_jump     (alu_jump),
        .jump_address (jump_address),
        .write_enable (write_enable),
        .alu_ne       (alu_ne),
        .halt_req     (halt_req),
        .rf_we        (rf_we),
        .pc           (pc),
`ifdef CPU_SEQ_WATCHDOG_EN
        .retired      (retired),
`endif
        .halted       (halted),
        .fault        (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold reset two cycles with a stray ack present, check reset values, release into FETCH.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        tick();
        check({tag, " pc"},     pc,                  32'd0);
        check({tag, " ir"},     instruction,         32'd0);
        check({tag, " req"},    32'(imem_req),       32'd0);
        check({tag, " rf_we"},  32'(rf_we),          32'd0);
        check({tag, " halted"}, 32'(halted),         32'd0);
        check({tag, " fault"},  32'(fault),          32'd0);
`ifdef CPU_SEQ_WATCHDOG_EN
        check({tag, " retired"}, retired,            32'd0);
`endif
        reset = 1'b0;
        imem_ack = 1'b0;
        tick();
        model_pc = 32'd0;
        model_ir = 32'd0;
    endtask

    // One instruction, entered in its first FETCH cycle; leaves in the next FETCH (or HALT).
    task automatic run_instr(input string tag, input logic [31:0] word, input int waits,
                             input logic dj, input logic aj, input logic ne, input logic we,
                             input logic [31:0] target, input logic halt,
                             input logic [31:0] exp_pc, input logic exp_we);
        check({tag, " f1 req"},  32'(imem_req), 32'd1);
        check({tag, " f1 addr"}, imem_addr,     model_pc);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, " wait req"},  32'(imem_req), 32'd1);
            check({tag, " wait addr"}, imem_addr,     model_pc);
            check({tag, " wait ir"},   instruction,   model_ir);
            check({tag, " wait we"},   32'(rf_we),    32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        model_ir = word;
        check({tag, " dec ir"},  instruction,   word);
        check({tag, " dec req"}, 32'(imem_req), 32'd0);
        check({tag, " dec we"},  32'(rf_we),    32'd0);
        do_jump = dj;
        alu_jump = aj;
        write_enable = we;
        jump_address = target;
        halt_req = 1'b1;
        imem_rdata = ~word;
        tick();
        imem_ack = 1'b0;
        halt_req = 1'b0;
        alu_ne = ne;
        check({tag, " ex ir"},     instruction,  word);
        check({tag, " ex we"},     32'(rf_we),   32'd0);
        check({tag, " ex halted"}, 32'(halted),  32'd0);
        tick();
        alu_ne = ~ne;
        check({tag, " wb we"}, 32'(rf_we), 32'(exp_we));
        halt_req = halt;
        tick();
        halt_req = 1'b0;
        check({tag, " pc"},     pc,             exp_pc);
        check({tag, " addr"},   imem_addr,      exp_pc);
        check({tag, " req"},    32'(imem_req),  32'(!halt));
        check({tag, " halted"}, 32'(halted),    32'(halt));
        check({tag, " we off"}, 32'(rf_we),     32'd0);
        model_pc = exp_pc;
    endtask

    initial begin
        do_reset("reset");

        //        tag         word           wt dj    aj    ne    we    target         halt  exp_pc         exp_we
        run_instr("addi",     32'h0010_0093, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b1);
        run_instr("delayed",  32'h0020_0113, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b1);
        run_instr("j5",       32'h0800_0005, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0);
        run_instr("j20",      32'h0800_0020, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0);
        run_instr("j7",       32'h0800_0007, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 32'h0000_0007, 1'b0);
        run_instr("bne take", 32'h1400_0010, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0);
        run_instr("j7 again", 32'h0800_0007, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 32'h0000_0007, 1'b0);
        run_instr("bne fall", 32'h1400_0010, 0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0008, 1'b0);
        run_instr("j max",    32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_instr("wrap halt",32'h0030_0193, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0000, 1'b1);

        // HALT holds with acks and halt requests arriving.
        for (int i = 0; i < 4; i++) begin
            imem_ack = i[0];
            imem_rdata = 32'hCAFE_0000;
            tick();
            check("halt hold req",    32'(imem_req), 32'd0);
            check("halt hold halted", 32'(halted),   32'd1);
            check("halt hold pc",     pc,            32'd0);
            check("halt hold ir",     instruction,   32'h0030_0193);
        end
        imem_ack = 1'b0;

        do_reset("rereset");
        run_instr("post reset", 32'h0040_0213, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b1);

        // Reset during EXECUTE abandons the instruction: no write strobe, no pc update.
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0293;
        tick();
        imem_ack = 1'b0;
        do_jump = 1'b0;
        write_enable = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("mid reset we",  32'(rf_we),    32'd0);
        check("mid reset pc",  pc,            32'd0);
        check("mid reset ir",  instruction,   32'd0);
        check("mid reset req", 32'(imem_req), 32'd0);
        tick();
        check("mid reset we2", 32'(rf_we),    32'd0);
        reset = 1'b0;
        tick();
        model_pc = 32'd0;
        model_ir = 32'd0;
        check("mid reset refetch", 32'(imem_req), 32'd1);

`ifdef CPU_SEQ_WATCHDOG_EN
        // No ack for 16 FETCH cycles: fault, halt, request dropped.
        for (int i = 0; i < 16; i++) begin
            check("wd wait req",   32'(imem_req), 32'd1);
            check("wd wait fault", 32'(fault),    32'd0);
            tick();
        end
        check("wd fault",  32'(fault),    32'd1);
        check("wd halted", 32'(halted),   32'd1);
        check("wd req",    32'(imem_req), 32'd0);
        tick();
        check("wd sticky", 32'(fault),    32'd1);

        // Ack on the limit cycle wins over the timeout.
        do_reset("wd reset");
        for (int i = 0; i < 15; i++) tick();
        imem_ack = 1'b1;
        imem_rdata = 32'h0060_0313;
        tick();
        imem_ack = 1'b0;
        check("wd limit ack ir",     instruction,  32'h0060_0313);
        check("wd limit ack fault",  32'(fault),   32'd0);
        check("wd limit ack halted", 32'(halted),  32'd0);
        do_jump = 1'b0;
        write_enable = 1'b1;
        tick();
        tick();
        tick();
        check("retired one", retired, 32'd1);
        check("retired pc",  pc,      32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
